memory_bus_arbiter: RTL and testbench

Shares the single data-memory port between two requesters: port 0 is the CPU data port and port 1 is a peripheral/DMA master.
- Round-robin arbitration, one transaction accepted per cycle.
- Synchronous memory with 1-cycle read latency; reads are pipelined, so a new request is accepted while the previous read returns.
- Optional bus lock lets a requester perform atomic read-modify-write sequences, bounded by a lock timeout.

---
 rtl/memory_bus_arbiter.sv | 88 ++++++++
 tb/tb_memory_bus_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin two-port arbiter for a synchronous memory with pipelined reads
// and a time-bounded bus lock for atomic read-modify-write sequences.
module memory_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_0,
    input  logic                  req_1,
    input  logic                  write_en_0,
    input  logic                  write_en_1,
    input  logic [ADDR_WIDTH-1:0] address_0,
    input  logic [ADDR_WIDTH-1:0] address_1,
    input  logic [DATA_WIDTH-1:0] write_value_0,
    input  logic [DATA_WIDTH-1:0] write_value_1,
    input  logic                  lock_0,
    input  logic                  lock_1,
    output logic                  ready_0,
    output logic                  ready_1,
    output logic                  read_valid_0,
    output logic                  read_valid_1,
    output logic [DATA_WIDTH-1:0] read_value_0,
    output logic [DATA_WIDTH-1:0] read_value_1,
    output logic                  lock_timeout,
    output logic                  memory_write_en,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic [DATA_WIDTH-1:0] memory_write_value,
    input  logic [DATA_WIDTH-1:0] memory_read_value
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    typedef enum logic [1:0] {UNLOCKED, LOCKED_0, LOCKED_1} state_t;
    state_t          state;
    logic [CW-1:0]   lock_count;
    logic            last_grant, pending_valid, pending_port;
    logic            grant_0, grant_1, grant_any, grant_lock, held_lock;
    always_comb begin
        grant_0            = req_0 && (state == LOCKED_0 || (state == UNLOCKED && (!req_1 || last_grant)));
        grant_1            = req_1 && (state == LOCKED_1 || (state == UNLOCKED && (!req_0 || !last_grant)));
        grant_any          = grant_0 || grant_1;
        grant_lock         = grant_1 ? lock_1 : grant_0 && lock_0;
        held_lock          = (state == LOCKED_1) ? lock_1 : lock_0;
        ready_0            = grant_0;
        ready_1            = grant_1;
        memory_write_en    = grant_0 ? write_en_0 : grant_1 && write_en_1;
        memory_address     = grant_0 ? address_0 : grant_1 ? address_1 : '0;
        memory_write_value = grant_0 ? write_value_0 : grant_1 ? write_value_1 : '0;
        read_valid_0       = pending_valid && !pending_port;
        read_valid_1       = pending_valid && pending_port;
        read_value_0       = read_valid_0 ? memory_read_value : '0;
        read_value_1       = read_valid_1 ? memory_read_value : '0;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= UNLOCKED;
            lock_count    <= '0;
            last_grant    <= 1'b1;
            pending_valid <= 1'b0;
            pending_port  <= 1'b0;
            lock_timeout  <= 1'b0;
        end else begin
            lock_timeout  <= 1'b0;
            pending_valid <= grant_any && !memory_write_en;
            if (grant_any) begin
                last_grant <= grant_1;
                if (!memory_write_en) pending_port <= grant_1;
            end
            if (state == UNLOCKED) begin
                if (grant_lock) begin
                    state      <= grant_1 ? LOCKED_1 : LOCKED_0;
                    lock_count <= CW'(1);
                end
            end else if (!held_lock) begin
                state      <= UNLOCKED;
                lock_count <= '0;
            end else if (lock_count == CW'(LOCK_MAX)) begin
                // forced release hands the next tie to the other port
                state        <= UNLOCKED;
                lock_count   <= '0;
                lock_timeout <= 1'b1;
                last_grant   <= (state == LOCKED_1);
            end else begin
                lock_count <= lock_count + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: directed vectors for memory_bus_arbiter with hand-computed expectations.
module tb_memory_bus_arbiter;
    logic        clock = 1'b0, reset_n = 1'b0;
    logic        req_0 = 0, req_1 = 0, write_en_0 = 0, write_en_1 = 0, lock_0 = 0, lock_1 = 0;
    logic [31:0] address_0 = 0, address_1 = 0, write_value_0 = 0, write_value_1 = 0;
    logic [31:0] memory_read_value = 0;
    logic        ready_0, ready_1, read_valid_0, read_valid_1, lock_timeout, memory_write_en;
    logic [31:0] read_value_0, read_value_1, memory_address, memory_write_value;
    int          checks = 0, failures = 0;

    memory_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LOCK_MAX(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_0(req_0), .req_1(req_1),
        .write_en_0(write_en_0), .write_en_1(write_en_1),
        .address_0(address_0), .address_1(address_1),
        .write_value_0(write_value_0), .write_value_1(write_value_1),
        .lock_0(lock_0), .lock_1(lock_1),
        .ready_0(ready_0), .ready_1(ready_1),
        .read_valid_0(read_valid_0), .read_valid_1(read_valid_1),
        .read_value_0(read_value_0), .read_value_1(read_value_1),
        .lock_timeout(lock_timeout),
        .memory_write_en(memory_write_en), .memory_address(memory_address),
        .memory_write_value(memory_write_value), .memory_read_value(memory_read_value)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req_0 = 0; req_1 = 0; write_en_0 = 0; write_en_1 = 0; lock_0 = 0; lock_1 = 0;
        address_0 = 0; address_1 = 0; write_value_0 = 0; write_value_1 = 0; memory_read_value = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rdy0"}, ready_0, 0);
        check({tag, "_rdy1"}, ready_1, 0);
        check({tag, "_rv0"}, read_valid_0, 0);
        check({tag, "_rv1"}, read_valid_1, 0);
        check({tag, "_val0"}, read_value_0, 0);
        check({tag, "_val1"}, read_value_1, 0);
        check({tag, "_lto"}, lock_timeout, 0);
        check({tag, "_mwe"}, memory_write_en, 0);
        check({tag, "_maddr"}, memory_address, 0);
        check({tag, "_mwv"}, memory_write_value, 0);
    endtask

    initial begin
        #2;
        check_quiet("reset");
        do_reset();
        check_quiet("post_reset");

        // single read by port 0
        req_0 = 1; address_0 = 32'h10;
        #1;
        check("t1_rdy0", ready_0, 1);
        check("t1_rdy1", ready_1, 0);
        check("t1_maddr", memory_address, 32'h10);
        check("t1_mwe", memory_write_en, 0);
        tick();
        req_0 = 0; memory_read_value = 32'h5;
        #1;
        check("t1_rv0", read_valid_0, 1);
        check("t1_val0", read_value_0, 32'h5);
        check("t1_rv1", read_valid_1, 0);
        check("t1_val1", read_value_1, 0);
        check("t1_rdy1b", ready_1, 0);
        tick();
        check("t1_rv0_clr", read_valid_0, 0);

        // both ports requesting: alternate starting with port 0
        do_reset();
        req_0 = 1; write_en_0 = 1; address_0 = 32'h20; write_value_0 = 32'hA;
        req_1 = 1; write_en_1 = 0; address_1 = 32'h24;
        for (int k = 0; k < 5; k++) begin
            memory_read_value = 32'h100 + k;
            #1;
            check($sformatf("t2_rdy0_%0d", k), ready_0, (k % 2) == 0);
            check($sformatf("t2_rdy1_%0d", k), ready_1, (k % 2) == 1);
            check($sformatf("t2_mwe_%0d", k), memory_write_en, (k % 2) == 0);
            check($sformatf("t2_maddr_%0d", k), memory_address, (k % 2) ? 32'h24 : 32'h20);
            check($sformatf("t2_mwv_%0d", k), memory_write_value, (k % 2) ? 32'h0 : 32'hA);
            check($sformatf("t2_rv1_%0d", k), read_valid_1, k == 2 || k == 4);
            check($sformatf("t2_val1_%0d", k), read_value_1, (k == 2 || k == 4) ? 32'h100 + k : 0);
            check($sformatf("t2_rv0_%0d", k), read_valid_0, 0);
            tick();
        end
        idle();
        tick();

        // back-to-back reads by port 1
        for (int c = 0; c < 5; c++) begin
            req_1 = c < 3; address_1 = 4 * c; memory_read_value = 32'h200 + c;
            #1;
            check($sformatf("t3_rdy1_%0d", c), ready_1, c < 3);
            if (c < 3) check($sformatf("t3_maddr_%0d", c), memory_address, 4 * c);
            check($sformatf("t3_rv1_%0d", c), read_valid_1, c >= 1 && c <= 3);
            check($sformatf("t3_val1_%0d", c), read_value_1, (c >= 1 && c <= 3) ? 32'h200 + c : 0);
            tick();
        end
        idle();

        // port 0 locks for three transactions while port 1 waits
        for (int c = 0; c < 5; c++) begin
            req_0 = c < 3; lock_0 = c < 3; write_en_0 = 1; address_0 = 32'h40;
            req_1 = 1; write_en_1 = 1; address_1 = 32'h44;
            #1;
            check($sformatf("t4_rdy0_%0d", c), ready_0, c < 3);
            check($sformatf("t4_rdy1_%0d", c), ready_1, c == 4);
            tick();
        end
        idle();

        // lock held past LOCK_MAX forces a release
        for (int c = 0; c < 12; c++) begin
            req_0 = 1; lock_0 = 1; write_en_0 = 1;
            req_1 = 1; write_en_1 = 1;
            #1;
            check($sformatf("t5_rdy0_%0d", c), ready_0, c != 9);
            check($sformatf("t5_rdy1_%0d", c), ready_1, c == 9);
            check($sformatf("t5_lto_%0d", c), lock_timeout, c == 9);
            tick();
        end
        idle();
        tick();
        tick();

        // reset in the cycle after a read grant drops the pending read
        req_0 = 1; address_0 = 32'h30;
        #1;
        check("t6_rdy0", ready_0, 1);
        tick();
        idle();
        memory_read_value = 32'h77;
        reset_n = 0;
        #1;
        check_quiet("t6_mid");
        tick();
        reset_n = 1;
        #1;
        req_0 = 1; req_1 = 1;
        #1;
        check("t6_tie_rdy0", ready_0, 1);
        check("t6_tie_rdy1", ready_1, 0);
        check("t6_rv0", read_valid_0, 0);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
